ex_muldiv_unit: RTL and testbench

Iterative multi-cycle integer multiply/divide unit in the EX stage, consuming the operands and function code that the ID/EX pipeline register presents. It owns the HI/LO architectural registers. It returns a stall to the front end, which holds the ID/EX register while an operation is in flight. Radix-2: one multiplier or quotient bit per cycle.

---
 rtl/ex_muldiv_unit.sv | 189 ++++++++++++++++++
 tb/tb_ex_muldiv_unit.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/ex_muldiv_unit.sv
// Radix-2 iterative multiply/divide unit for the EX stage; owns HI/LO and stalls the front end.
// Optional build macro MULDIV_EARLY_EXIT_EN lets multiplies finish as soon as the remaining multiplier bits are zero.
module ex_muldiv_unit #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             iStart,
    input  logic [1:0]       iOp,
    input  logic [WIDTH-1:0] iRegOut1,
    input  logic [WIDTH-1:0] iRegOut2,
    input  logic             iFlush,
    output logic [WIDTH-1:0] oHi,
    output logic [WIDTH-1:0] oLo,
    output logic             oBusy,
    output logic             oDone,
    output logic             oStall
);

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        DONE
    } state_e;

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [2*WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0]   operand_q, operand_d;
    logic [WIDTH-1:0]   dividend_q, dividend_d;
    logic               isDiv_q, isDiv_d;
    logic               negRes_q, negRes_d;
    logic               negRem_q, negRem_d;
    logic               divZero_q, divZero_d;
    logic [WIDTH-1:0]   hi_q, hi_d;
    logic [WIDTH-1:0]   lo_q, lo_d;

    logic               signedOp;
    logic               signA;
    logic               signB;
    logic [WIDTH-1:0]   absA;
    logic [WIDTH-1:0]   absB;

    logic [WIDTH:0]     mulSum;
    logic [2*WIDTH-1:0] mulNext;
    logic [2*WIDTH:0]   divShift;
    logic [WIDTH:0]     divDiff;
    logic [2*WIDTH-1:0] divNext;
    logic [2*WIDTH-1:0] stepNext;
    logic [2*WIDTH-1:0] finalAcc;
    logic               lastIter;
    logic [2*WIDTH-1:0] signedProd;
    logic [WIDTH-1:0]   resultHi;
    logic [WIDTH-1:0]   resultLo;

    // Only mult/div (iOp[0]==0) treat operands as two's complement.
    assign signedOp = ~iOp[0];
    assign signA    = signedOp & iRegOut1[WIDTH-1];
    assign signB    = signedOp & iRegOut2[WIDTH-1];
    assign absA     = signA ? -iRegOut1 : iRegOut1;
    assign absB     = signB ? -iRegOut2 : iRegOut2;

    assign mulSum   = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, operand_q} : '0);
    assign mulNext  = {mulSum, acc_q[WIDTH-1:1]};

    // Restoring divide: remainder lives in the upper half, quotient bits shift into the lower half.
    assign divShift = {acc_q, 1'b0};
    assign divDiff  = divShift[2*WIDTH:WIDTH] - {1'b0, operand_q};
    assign divNext  = divDiff[WIDTH] ? divShift[2*WIDTH-1:0]
                                     : {divDiff[WIDTH-1:0], divShift[WIDTH-1:1], 1'b1};
    assign stepNext = isDiv_q ? divNext : mulNext;

`ifdef MULDIV_EARLY_EXIT_EN
    logic [WIDTH-2:0] restMask;
    logic             mulRestZero;

    // Once the unconsumed multiplier bits are zero, the product is the partial sum shifted into place.
    assign restMask    = ~({(WIDTH-1){1'b1}} << cnt_q);
    assign mulRestZero = (acc_q[WIDTH-1:1] & restMask) == '0;
    assign lastIter    = (cnt_q == '0) | (~isDiv_q & mulRestZero);
    assign finalAcc    = isDiv_q ? stepNext : (mulNext >> cnt_q);
`else
    assign lastIter    = (cnt_q == '0);
    assign finalAcc    = stepNext;
`endif

    assign signedProd = negRes_q ? -finalAcc : finalAcc;

    // Sign correction and the divide-by-zero override applied to the final iteration's value.
    always_comb begin : fixUp
        resultHi = signedProd[2*WIDTH-1:WIDTH];
        resultLo = signedProd[WIDTH-1:0];
        if (isDiv_q) begin
            if (divZero_q) begin
                resultHi = dividend_q;
                resultLo = '1;
            end else begin
                resultHi = negRem_q ? -finalAcc[2*WIDTH-1:WIDTH] : finalAcc[2*WIDTH-1:WIDTH];
                resultLo = negRes_q ? -finalAcc[WIDTH-1:0] : finalAcc[WIDTH-1:0];
            end
        end
    end

    always_comb begin : nextState
        state_d    = state_q;
        cnt_d      = cnt_q;
        acc_d      = acc_q;
        operand_d  = operand_q;
        dividend_d = dividend_q;
        isDiv_d    = isDiv_q;
        negRes_d   = negRes_q;
        negRem_d   = negRem_q;
        divZero_d  = divZero_q;
        hi_d       = hi_q;
        lo_d       = lo_q;
        case (state_q)
            IDLE, DONE: begin
                state_d = IDLE;
                if (iStart && !iFlush) begin
                    state_d    = BUSY;
                    cnt_d      = CNT_W'(WIDTH - 1);
                    isDiv_d    = iOp[1];
                    negRes_d   = signA ^ signB;
                    negRem_d   = signA;
                    divZero_d  = iOp[1] & (iRegOut2 == '0);
                    dividend_d = iRegOut1;
                    if (iOp[1]) begin
                        operand_d = absB;
                        acc_d     = {{WIDTH{1'b0}}, absA};
                    end else begin
                        operand_d = absA;
                        acc_d     = {{WIDTH{1'b0}}, absB};
                    end
                end
            end
            BUSY: begin
                if (iFlush) begin
                    state_d = IDLE;
                end else begin
                    acc_d = stepNext;
                    cnt_d = cnt_q - CNT_W'(1);
                    if (lastIter) begin
                        state_d = DONE;
                        cnt_d   = '0;
                        hi_d    = resultHi;
                        lo_d    = resultLo;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin : stateReg
        if (rst) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            acc_q      <= '0;
            operand_q  <= '0;
            dividend_q <= '0;
            isDiv_q    <= 1'b0;
            negRes_q   <= 1'b0;
            negRem_q   <= 1'b0;
            divZero_q  <= 1'b0;
            hi_q       <= '0;
            lo_q       <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            acc_q      <= acc_d;
            operand_q  <= operand_d;
            dividend_q <= dividend_d;
            isDiv_q    <= isDiv_d;
            negRes_q   <= negRes_d;
            negRem_q   <= negRem_d;
            divZero_q  <= divZero_d;
            hi_q       <= hi_d;
            lo_q       <= lo_d;
        end
    end

    assign oHi    = hi_q;
    assign oLo    = lo_q;
    assign oBusy  = (state_q == BUSY);
    assign oDone  = (state_q == DONE);
    assign oStall = oBusy | (iStart & (state_q == BUSY));

endmodule

// File: tb/tb_ex_muldiv_unit.sv
// Self-checking bench for ex_muldiv_unit: directed vector table, corner-case sequences and
// randomized operations checked against an arithmetic reference model.
module tb_ex_muldiv_unit;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        iStart = 1'b0;
    logic [1:0]  iOp = 2'b00;
    logic [31:0] iRegOut1 = '0;
    logic [31:0] iRegOut2 = '0;
    logic        iFlush = 1'b0;
    logic [31:0] oHi;
    logic [31:0] oLo;
    logic        oBusy;
    logic        oDone;
    logic        oStall;

    int          checks = 0;
    int          failures = 0;
    logic [31:0] lastHi = '0;
    logic [31:0] lastLo = '0;

    typedef struct {
        logic [1:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] hi;
        logic [31:0] lo;
    } vec_t;

    vec_t vecs[13];

    ex_muldiv_unit #(.WIDTH(32), .CNT_W(5)) dut (
        .clk      (clk),
        .rst      (rst),
        .iStart   (iStart),
        .iOp      (iOp),
        .iRegOut1 (iRegOut1),
        .iRegOut2 (iRegOut2),
        .iFlush   (iFlush),
        .oHi      (oHi),
        .oLo      (oLo),
        .oBusy    (oBusy),
        .oDone    (oDone),
        .oStall   (oStall)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got %h expected %h", name, actual, expected);
        end
    endtask

    // Reference arithmetic: full-width products and truncating division straight from the op definitions.
    function automatic void refModel(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                                     output logic [31:0] hi, output logic [31:0] lo);
        longint      sp;
        logic [63:0] up;
        int          q;
        int          r;
        hi = '0;
        lo = '0;
        case (op)
            2'b00: begin
                sp = longint'($signed(a)) * longint'($signed(b));
                hi = sp[63:32];
                lo = sp[31:0];
            end
            2'b01: begin
                up = {32'b0, a} * {32'b0, b};
                hi = up[63:32];
                lo = up[31:0];
            end
            default: begin
                if (b == 32'd0) begin
                    hi = a;
                    lo = 32'hFFFF_FFFF;
                end else if (op == 2'b10 && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
                    hi = 32'd0;
                    lo = 32'h8000_0000;
                end else if (op == 2'b10) begin
                    q  = $signed(a) / $signed(b);
                    r  = $signed(a) % $signed(b);
                    hi = r;
                    lo = q;
                end else begin
                    hi = a % b;
                    lo = a / b;
                end
            end
        endcase
    endfunction

    function automatic int expLatency(input logic [1:0] op, input logic [31:0] b);
        int n;
        n = 32;
`ifdef MULDIV_EARLY_EXIT_EN
        if (!op[1]) begin
            logic [31:0] mag;
            mag = (op == 2'b00 && b[31]) ? -b : b;
            n = 1;
            for (int i = 0; i < 32; i++) if (mag[i]) n = i + 1;
        end
`else
        if (op[1]) n = 32;
`endif
        return n;
    endfunction

    task automatic applyStimulus(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
        @(negedge clk);
        iStart   = 1'b1;
        iOp      = op;
        iRegOut1 = a;
        iRegOut2 = b;
        @(negedge clk);
        iStart   = 1'b0;
        iRegOut1 = $urandom;
        iRegOut2 = $urandom;
    endtask

    task automatic runOp(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] expHi, input logic [31:0] expLo, input string tag);
        int k;
        int stalls;
        int lat;
        lat = expLatency(op, b);
        applyStimulus(op, a, b);
        k = 0;
        stalls = 0;
        while (!oDone && k < 100) begin
            if (oStall) stalls++;
            k++;
            @(negedge clk);
        end
        checkOutput({tag, " latency"}, k, lat);
        checkOutput({tag, " stallCycles"}, stalls, lat);
        checkOutput({tag, " stallAtDone"}, {31'b0, oStall}, 32'd0);
        checkOutput({tag, " hi"}, oHi, expHi);
        checkOutput({tag, " lo"}, oLo, expLo);
        lastHi = expHi;
        lastLo = expLo;
        @(negedge clk);
        checkOutput({tag, " donePulse"}, {31'b0, oDone}, 32'd0);
    endtask

    initial begin
        int          k;
        int          doneSeen;
        logic [1:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] eh;
        logic [31:0] el;

        vecs[0]  = '{2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001};
        vecs[1]  = '{2'b00, 32'hFFFF_FFF9, 32'h0000_0003, 32'hFFFF_FFFF, 32'hFFFF_FFEB};
        vecs[2]  = '{2'b10, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, 32'hFFFF_FFFD};
        vecs[3]  = '{2'b11, 32'd100,       32'd0,         32'd100,       32'hFFFF_FFFF};
        vecs[4]  = '{2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000};
        vecs[5]  = '{2'b10, 32'hFFFF_FFF9, 32'd0,         32'hFFFF_FFF9, 32'hFFFF_FFFF};
        vecs[6]  = '{2'b00, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000};
        vecs[7]  = '{2'b11, 32'd50,        32'd5,         32'd0,         32'd10};
        vecs[8]  = '{2'b10, 32'd7,         32'hFFFF_FFFE, 32'd1,         32'hFFFF_FFFD};
        vecs[9]  = '{2'b00, 32'd0,         32'd12345,     32'd0,         32'd0};
        vecs[10] = '{2'b01, 32'h0000_1234, 32'd1,         32'd0,         32'h0000_1234};
        vecs[11] = '{2'b01, 32'd2,         32'd3,         32'd0,         32'd6};
        vecs[12] = '{2'b00, 32'h0001_0000, 32'hFFFF_0000, 32'hFFFF_FFFF, 32'h0000_0000};

        repeat (2) @(negedge clk);
        checkOutput("reset hi", oHi, 32'd0);
        checkOutput("reset lo", oLo, 32'd0);
        checkOutput("reset busy", {31'b0, oBusy}, 32'd0);
        checkOutput("reset done", {31'b0, oDone}, 32'd0);
        checkOutput("reset stall", {31'b0, oStall}, 32'd0);
        rst = 1'b0;

        for (int i = 0; i < 13; i++) begin
            runOp(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].hi, vecs[i].lo, $sformatf("vec%0d", i));
        end

        // Start and flush together in IDLE: flush wins.
        @(negedge clk);
        iStart = 1'b1; iFlush = 1'b1; iOp = 2'b01; iRegOut1 = 32'd9; iRegOut2 = 32'd9;
        @(negedge clk);
        iStart = 1'b0; iFlush = 1'b0;
        checkOutput("startFlush busy", {31'b0, oBusy}, 32'd0);

        // Flush on BUSY cycle 10 of divu 50/5.
        applyStimulus(2'b11, 32'd50, 32'd5);
        repeat (9) @(negedge clk);
        checkOutput("flush preBusy", {31'b0, oBusy}, 32'd1);
        iFlush = 1'b1;
        @(negedge clk);
        iFlush = 1'b0;
        checkOutput("flush busyDrop", {31'b0, oBusy}, 32'd0);
        doneSeen = 0;
        repeat (35) begin
            if (oDone) doneSeen++;
            @(negedge clk);
        end
        checkOutput("flush noDone", doneSeen, 32'd0);
        checkOutput("flush hiKept", oHi, lastHi);
        checkOutput("flush loKept", oLo, lastLo);

        // Back-to-back: mult 2*3, then multu 4*5 started in the DONE cycle.
        applyStimulus(2'b00, 32'd2, 32'd3);
        k = 0;
        while (!oDone && k < 100) begin k++; @(negedge clk); end
        checkOutput("b2b first lo", oLo, 32'd6);
        iStart = 1'b1; iOp = 2'b01; iRegOut1 = 32'd4; iRegOut2 = 32'd5;
        @(negedge clk);
        iOp = 2'b11; iRegOut1 = 32'hDEAD_BEEF; iRegOut2 = 32'd0;
        checkOutput("b2b busy", {31'b0, oBusy}, 32'd1);
        checkOutput("b2b ignoredStartStall", {31'b0, oStall}, 32'd1);
        k = 1;
        while (!oDone && k < 100) begin k++; @(negedge clk); end
        iStart = 1'b0;
        checkOutput("b2b gap", k, 1 + expLatency(2'b01, 32'd5));
        checkOutput("b2b second lo", oLo, 32'd20);
        checkOutput("b2b second hi", oHi, 32'd0);
        @(negedge clk);
        checkOutput("b2b idleAfter", {31'b0, oBusy}, 32'd0);

        // Asynchronous reset on BUSY cycle 5.
        applyStimulus(2'b10, 32'd100, 32'd7);
        repeat (4) @(negedge clk);
        rst = 1'b1;
        #1;
        checkOutput("midReset hi", oHi, 32'd0);
        checkOutput("midReset lo", oLo, 32'd0);
        checkOutput("midReset busy", {31'b0, oBusy}, 32'd0);
        checkOutput("midReset done", {31'b0, oDone}, 32'd0);
        checkOutput("midReset stall", {31'b0, oStall}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        doneSeen = 0;
        repeat (40) begin
            if (oDone) doneSeen++;
            @(negedge clk);
        end
        checkOutput("midReset noDone", doneSeen, 32'd0);
        checkOutput("midReset loStays", oLo, 32'd0);

        // Randomized operations against the reference model.
        for (int i = 0; i < 16; i++) begin
            op = 2'($urandom_range(0, 3));
            a  = $urandom;
            if (i % 4 == 1) a = 32'($urandom_range(0, 1000));
            b  = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 15)) : $urandom;
            if (i % 5 == 2) b = -32'($urandom_range(1, 9));
            refModel(op, a, b, eh, el);
            runOp(op, a, b, eh, el, $sformatf("rand%0d op%0d", i, op));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
        $finish;
    end

endmodule
